// File: rtl/wfifo_level_sync.sv
// wfifo_level_sync: brings the Gray read pointer into wclk and derives registered
// occupancy, free space, almost-full, overflow and high-watermark status.
module wfifo_level_sync #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              winc,
  input  logic              wfull,
  input  logic [ADDRSIZE:0] afull_thresh,
  input  logic              ovf_clr,
  input  logic              hwm_clr,
  output logic [ADDRSIZE:0] wq2_rptr,
  output logic [ADDRSIZE:0] wlevel,
  output logic [ADDRSIZE:0] wfree,
  output logic              wprog_full,
  output logic              woverflow,
  output logic [ADDRSIZE:0] whwm
);
  localparam int P = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] D = P'(2 ** ADDRSIZE);
  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] rbin, wbin, diff, lvl_next;
  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    for (int i = 0; i <= ADDRSIZE; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  assign wq2_rptr = sync_q[SYNC_STAGES-1];
  assign rbin     = gray2bin(wq2_rptr);
  assign wbin     = gray2bin(wptr);
  assign diff     = wbin - rbin;
  // clamp only bites on corrupt pointer pairs
  assign lvl_next = (diff > D) ? D : diff;
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n)
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      wlevel     <= '0;
      wfree      <= D;
      wprog_full <= 1'b0;
      woverflow  <= 1'b0;
      whwm       <= '0;
    end else begin
      wlevel     <= lvl_next;
      wfree      <= D - lvl_next;
      wprog_full <= (afull_thresh != '0) && (lvl_next >= afull_thresh);
      woverflow  <= (winc && wfull) || (woverflow && !ovf_clr);
      whwm       <= (hwm_clr || lvl_next > whwm) ? lvl_next : whwm;
    end
endmodule

// File: tb/tb_wfifo_level_sync.sv
// tb_wfifo_level_sync: scoreboard bench for the write-side level/status block.
module tb_wfifo_level_sync;
  typedef struct packed {
    logic [4:0] lvl;
    logic [4:0] free;
    logic       pf;
    logic [4:0] hwm;
  } exp_t;
  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [4:0] rptr = '0, wptr = '0, afull_thresh = '0;
  logic       winc = 1'b0, wfull = 1'b0, ovf_clr = 1'b0, hwm_clr = 1'b0;
  logic [4:0] wq2_rptr, wlevel, wfree, whwm;
  logic       wprog_full, woverflow;
  exp_t       sb [$];
  logic       ovq [$];
  exp_t       e;
  logic       eo;
  int         checks = 0;
  int         errors = 0;
  always #5 wclk = ~wclk;
  wfifo_level_sync #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wptr(wptr), .winc(winc),
    .wfull(wfull), .afull_thresh(afull_thresh), .ovf_clr(ovf_clr), .hwm_clr(hwm_clr),
    .wq2_rptr(wq2_rptr), .wlevel(wlevel), .wfree(wfree), .wprog_full(wprog_full),
    .woverflow(woverflow), .whwm(whwm)
  );
  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction
  function automatic exp_t mk(input int l, input logic pf, input int h);
    return '{lvl: 5'(l), free: 5'(16 - l), pf: pf, hwm: 5'(h)};
  endfunction
  function automatic exp_t obs();
    return '{lvl: wlevel, free: wfree, pf: wprog_full, hwm: whwm};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) @(posedge wclk);
    #1;
  endtask
  task automatic test_reset;
    wrst_n = 1'b0;
    repeat (3) @(posedge wclk);
    #1;
    sb.push_back(mk(0, 1'b0, 0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e || woverflow !== 1'b0 || wq2_rptr !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: got lvl=%0d free=%0d pf=%b hwm=%0d ovf=%b q2=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d ovf=0 q2=0",
               wlevel, wfree, wprog_full, whwm, woverflow, wq2_rptr, e.lvl, e.free, e.pf, e.hwm);
    end
    wrst_n = 1'b1;
    sb.push_back(mk(0, 1'b0, 0));
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e || woverflow !== 1'b0 || wq2_rptr !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: got lvl=%0d free=%0d pf=%b hwm=%0d ovf=%b q2=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d ovf=0 q2=0",
               wlevel, wfree, wprog_full, whwm, woverflow, wq2_rptr, e.lvl, e.free, e.pf, e.hwm);
    end
  endtask
  task automatic test_fill;
    afull_thresh = 5'd14;
    rptr = g(0);
    for (int i = 1; i <= 16; i++) begin
      wptr = g(i);
      sb.push_back(mk(i, i >= 14, i));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL fill[%0d]: got lvl=%0d free=%0d pf=%b hwm=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d",
                 i, wlevel, wfree, wprog_full, whwm, e.lvl, e.free, e.pf, e.hwm);
      end
    end
  endtask
  task automatic test_read_latency;
    rptr = g(4);
    for (int k = 1; k <= 2; k++) begin
      sb.push_back(mk(16, 1'b1, 16));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e || wq2_rptr !== (k == 2 ? g(4) : g(0))) begin
        errors++;
        $display("FAIL rd_lat_edge%0d: got lvl=%0d free=%0d pf=%b hwm=%0d q2=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d q2=%0d",
                 k, wlevel, wfree, wprog_full, whwm, wq2_rptr, e.lvl, e.free, e.pf, e.hwm, (k == 2 ? g(4) : g(0)));
      end
    end
    sb.push_back(mk(12, 1'b0, 16));
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL rd_lat_edge3: got lvl=%0d free=%0d pf=%b hwm=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d",
               wlevel, wfree, wprog_full, whwm, e.lvl, e.free, e.pf, e.hwm);
    end
  endtask
  task automatic test_wrap;
    int tbl [5][3] = '{'{3, 27, 8}, '{0, 16, 16}, '{20, 0, 16}, '{1, 30, 3}, '{31, 29, 2}};
    for (int i = 0; i < 5; i++) begin
      wptr = g(tbl[i][0]);
      rptr = g(tbl[i][1]);
      sb.push_back(mk(tbl[i][2], tbl[i][2] >= 14, 16));
      tick(3);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL wrap w=%0d r=%0d: got lvl=%0d free=%0d pf=%b hwm=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d",
                 tbl[i][0], tbl[i][1], wlevel, wfree, wprog_full, whwm, e.lvl, e.free, e.pf, e.hwm);
      end
    end
  endtask
  task automatic test_thresh;
    int th [4] = '{0, 16, 17, 13};
    wptr = g(16);
    rptr = g(0);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      afull_thresh = 5'(th[i]);
      sb.push_back(mk(16, th[i] != 0 && 16 >= th[i], 16));
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL thresh=%0d: got lvl=%0d free=%0d pf=%b hwm=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d",
                 th[i], wlevel, wfree, wprog_full, whwm, e.lvl, e.free, e.pf, e.hwm);
      end
    end
    afull_thresh = 5'd14;
  endtask
  task automatic test_overflow;
    logic [3:0] st [6] = '{4'b0100, 4'b1100, 4'b0100, 4'b1110, 4'b0010, 4'b0100};
    logic       ex [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      {winc, wfull, ovf_clr} = st[i][3:1];
      ovq.push_back(ex[i]);
      tick();
      eo = ovq.pop_front();
      checks++;
      if (woverflow !== eo) begin
        errors++;
        $display("FAIL overflow_step%0d: got ovf=%b, want %b", i, woverflow, eo);
      end
    end
    {winc, wfull, ovf_clr} = 3'b000;
  endtask
  task automatic test_hwm_reset;
    wptr = g(5);
    rptr = g(0);
    sb.push_back(mk(5, 1'b0, 16));
    tick(3);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL hwm_pre: got lvl=%0d hwm=%0d, want lvl=%0d hwm=%0d", wlevel, whwm, e.lvl, e.hwm);
    end
    hwm_clr = 1'b1;
    sb.push_back(mk(5, 1'b0, 5));
    tick();
    hwm_clr = 1'b0;
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL hwm_clr: got lvl=%0d hwm=%0d, want lvl=%0d hwm=%0d", wlevel, whwm, e.lvl, e.hwm);
    end
    wptr = g(9);
    winc = 1'b1;
    wfull = 1'b1;
    sb.push_back(mk(9, 1'b0, 9));
    tick();
    {winc, wfull} = 2'b00;
    e = sb.pop_front();
    checks++;
    if (obs() !== e || woverflow !== 1'b1) begin
      errors++;
      $display("FAIL hwm_grow: got lvl=%0d hwm=%0d ovf=%b, want lvl=%0d hwm=%0d ovf=1", wlevel, whwm, woverflow, e.lvl, e.hwm);
    end
    #2 wrst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 1'b0, 0));
    e = sb.pop_front();
    checks++;
    if (obs() !== e || woverflow !== 1'b0 || wq2_rptr !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: got lvl=%0d free=%0d pf=%b hwm=%0d ovf=%b, want lvl=0 free=16 pf=0 hwm=0 ovf=0",
               wlevel, wfree, wprog_full, whwm, woverflow);
    end
    tick();
    wrst_n = 1'b1;
    sb.push_back(mk(9, 1'b0, 9));
    tick(3);
    e = sb.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL post_reset: got lvl=%0d free=%0d pf=%b hwm=%0d, want lvl=%0d free=%0d pf=%b hwm=%0d",
               wlevel, wfree, wprog_full, whwm, e.lvl, e.free, e.pf, e.hwm);
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_read_latency();
    test_wrap();
    test_thresh();
    test_overflow();
    test_hwm_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
